// File: rtl/reg_file_sb.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_sb
// Description : Register file with two combinational read ports, one
//               synchronous write port and a per-register pending
//               scoreboard.
//               - Register 0 can be made hardwired zero.
//               - A write can be bypassed to the read ports in the same cycle.
//               - The stack-pointer register has its own reset value.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file_sb #(
    parameter int              DATA_W   = 32,
    parameter int              ADDR_W   = 5,
    parameter int              ZERO_REG = 1,
    parameter int              BYPASS   = 1,
    parameter int              SP_IDX   = 29,
    parameter logic [DATA_W-1:0] SP_INIT  = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              We,
    input  logic [ADDR_W-1:0] WA,
    input  logic [DATA_W-1:0] DW,
    input  logic [ADDR_W-1:0] AR1,
    input  logic [ADDR_W-1:0] AR2,
    output logic [DATA_W-1:0] DR1,
    output logic [DATA_W-1:0] DR2,
    output logic              Rv1,
    output logic              Rv2,
    input  logic              Res,
    input  logic [ADDR_W-1:0] RA,
    output logic              Busy,
    output logic [ADDR_W:0]   PendCnt
);

    localparam int c_DEPTH = 2**ADDR_W;
    localparam bit c_ZR    = (ZERO_REG != 0);
    localparam bit c_BYP   = (BYPASS != 0);

    logic [DATA_W-1:0]  r_rf [c_DEPTH];
    logic [c_DEPTH-1:0] r_pend;
    logic [ADDR_W:0]    r_pend_cnt;
    logic               r_busy;

    logic               w_we_ok;
    logic               w_res_ok;
    logic               w_set;
    logic               w_clr;
    logic [ADDR_W:0]    w_cnt_nxt;

    // Qualify write/reserve: register 0 swallows both when hardwired to zero
    always_comb begin
        w_we_ok  = We  && !(c_ZR && (WA == '0));
        w_res_ok = Res && !(c_ZR && (RA == '0));
        // Count changes only on real pend transitions; a reserve to the same
        // address as the write keeps the bit set, so that write clears nothing
        w_set     = w_res_ok && !r_pend[RA];
        w_clr     = w_we_ok && r_pend[WA] && !(w_res_ok && (RA == WA));
        w_cnt_nxt = r_pend_cnt + {{ADDR_W{1'b0}}, w_set} - {{ADDR_W{1'b0}}, w_clr};
    end

    // Register storage: reset preset (stack pointer), then qualified writes
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_rf[i] <= (i == SP_IDX) ? SP_INIT : '0;
            end
        end else if (w_we_ok) begin
            r_rf[WA] <= DW;
        end
    end

    // Pending vector: write clears, reserve sets; the later set wins on a clash
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend <= '0;
        end else begin
            if (w_we_ok) begin
                r_pend[WA] <= 1'b0;
            end
            if (w_res_ok) begin
                r_pend[RA] <= 1'b1;
            end
        end
    end

    // Pending count and busy flag track pend on the same edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend_cnt <= '0;
            r_busy     <= 1'b0;
        end else begin
            r_pend_cnt <= w_cnt_nxt;
            r_busy     <= (w_cnt_nxt != '0);
        end
    end

    // Read port 1: zero register, then bypass (suppressed while in reset), then array
    always_comb begin
        DR1 = r_rf[AR1];
        Rv1 = !r_pend[AR1];
        if (c_ZR && (AR1 == '0)) begin
            DR1 = '0;
            Rv1 = 1'b1;
        end else if (c_BYP && We && !rst && (WA == AR1)) begin
            DR1 = DW;
            Rv1 = 1'b1;
        end
    end

    // Read port 2: same resolution as port 1, independently
    always_comb begin
        DR2 = r_rf[AR2];
        Rv2 = !r_pend[AR2];
        if (c_ZR && (AR2 == '0)) begin
            DR2 = '0;
            Rv2 = 1'b1;
        end else if (c_BYP && We && !rst && (WA == AR2)) begin
            DR2 = DW;
            Rv2 = 1'b1;
        end
    end

    assign Busy    = r_busy;
    assign PendCnt = r_pend_cnt;

endmodule
`default_nettype wire

// File: tb/tb_reg_file_sb.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_file_sb
// Description : Self-checking bench for reg_file_sb.
//               - Table of per-cycle vectors.
//               - Hand-written fill/drain sequence of the scoreboard.
//               - Expected values are queued when stimulus is driven.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_file_sb;

    localparam int              c_DW      = 32;
    localparam int              c_AW      = 5;
    localparam logic [31:0]     c_SP_INIT = 32'h0000_0050;

    logic              clk;
    logic              rst;
    logic              we;
    logic [c_AW-1:0]   wa;
    logic [c_DW-1:0]   dw;
    logic [c_AW-1:0]   ar1;
    logic [c_AW-1:0]   ar2;
    logic [c_DW-1:0]   dr1;
    logic [c_DW-1:0]   dr2;
    logic              rv1;
    logic              rv2;
    logic              res;
    logic [c_AW-1:0]   ra;
    logic              busy;
    logic [c_AW:0]     pcnt;

    reg_file_sb #(
        .DATA_W   (c_DW),
        .ADDR_W   (c_AW),
        .ZERO_REG (1),
        .BYPASS   (1),
        .SP_IDX   (29),
        .SP_INIT  (c_SP_INIT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .We      (we),
        .WA      (wa),
        .DW      (dw),
        .AR1     (ar1),
        .AR2     (ar2),
        .DR1     (dr1),
        .DR2     (dr2),
        .Rv1     (rv1),
        .Rv2     (rv2),
        .Res     (res),
        .RA      (ra),
        .Busy    (busy),
        .PendCnt (pcnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] dw;
        logic        res;
        logic [4:0]  ra;
        logic [4:0]  ar1;
        logic [4:0]  ar2;
        bit          chk;
        logic [31:0] dr1;
        logic        rv1;
        logic [31:0] dr2;
        logic        rv2;
        logic        busy;
        logic [5:0]  cnt;
    } vec_t;

    typedef struct {
        logic [31:0] dr1;
        logic        rv1;
        logic [31:0] dr2;
        logic        rv2;
        logic        busy;
        logic [5:0]  cnt;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];
    vec_t tbl[$];

    function automatic vec_t mk(
        input logic r, input logic w, input logic [4:0] a_w, input logic [31:0] d,
        input logic s, input logic [4:0] a_r, input logic [4:0] a1, input logic [4:0] a2,
        input bit c, input logic [31:0] e1, input logic v1, input logic [31:0] e2,
        input logic v2, input logic b, input logic [5:0] n);
        vec_t v;
        v.rst = r;  v.we = w;   v.wa = a_w; v.dw = d;
        v.res = s;  v.ra = a_r; v.ar1 = a1; v.ar2 = a2;
        v.chk = c;  v.dr1 = e1; v.rv1 = v1; v.dr2 = e2; v.rv2 = v2;
        v.busy = b; v.cnt = n;
        return v;
    endfunction

    task automatic cmp(input string name, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    // One cycle: drive at negedge, queue expectations, sample before posedge
    task automatic step(input vec_t v, input int row);
        exp_t e;
        @(negedge clk);
        rst = v.rst; we = v.we; wa = v.wa; dw = v.dw;
        res = v.res; ra = v.ra; ar1 = v.ar1; ar2 = v.ar2;
        if (v.chk) begin
            e.dr1 = v.dr1; e.rv1 = v.rv1; e.dr2 = v.dr2; e.rv2 = v.rv2;
            e.busy = v.busy; e.cnt = v.cnt;
            sb_q.push_back(e);
        end
        #3;
        if (v.chk) begin
            e = sb_q.pop_front();
            cmp("DR1",     row, dr1, e.dr1);
            cmp("Rv1",     row, {31'd0, rv1}, {31'd0, e.rv1});
            cmp("DR2",     row, dr2, e.dr2);
            cmp("Rv2",     row, {31'd0, rv2}, {31'd0, e.rv2});
            cmp("Busy",    row, {31'd0, busy}, {31'd0, e.busy});
            cmp("PendCnt", row, {26'd0, pcnt}, {26'd0, e.cnt});
        end
        @(posedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; we = 1'b0; wa = '0; dw = '0; res = 1'b0; ra = '0; ar1 = '0; ar2 = '0;

        //            rst we wa  dw            res ra  ar1 ar2 chk dr1           rv1 dr2          rv2 busy cnt
        tbl.push_back(mk(1, 0, 0,  32'h0,        0, 0,  0,  0,  0, 32'h0,        1, 32'h0,        1, 0, 0));
        tbl.push_back(mk(0, 0, 0,  32'h0,        0, 0,  29, 7,  1, 32'h50,       1, 32'h0,        1, 0, 0));
        tbl.push_back(mk(0, 1, 5,  32'hDEADBEEF, 0, 0,  5,  29, 1, 32'hDEADBEEF, 1, 32'h50,       1, 0, 0));
        tbl.push_back(mk(0, 0, 0,  32'h0,        0, 0,  5,  6,  1, 32'hDEADBEEF, 1, 32'h0,        1, 0, 0));
        tbl.push_back(mk(0, 1, 0,  32'h1234,     0, 0,  0,  0,  1, 32'h0,        1, 32'h0,        1, 0, 0));
        tbl.push_back(mk(0, 0, 0,  32'h0,        1, 0,  0,  0,  1, 32'h0,        1, 32'h0,        1, 0, 0));
        tbl.push_back(mk(0, 0, 0,  32'h0,        0, 0,  0,  0,  1, 32'h0,        1, 32'h0,        1, 0, 0));
        tbl.push_back(mk(0, 0, 0,  32'h0,        1, 3,  3,  8,  1, 32'h0,        1, 32'h0,        1, 0, 0));
        tbl.push_back(mk(0, 0, 0,  32'h0,        1, 8,  3,  8,  1, 32'h0,        0, 32'h0,        1, 1, 1));
        tbl.push_back(mk(0, 0, 0,  32'h0,        0, 0,  3,  8,  1, 32'h0,        0, 32'h0,        0, 1, 2));
        tbl.push_back(mk(0, 1, 3,  32'h33,       0, 0,  3,  8,  1, 32'h33,       1, 32'h0,        0, 1, 2));
        tbl.push_back(mk(0, 0, 0,  32'h0,        0, 0,  3,  8,  1, 32'h33,       1, 32'h0,        0, 1, 1));
        tbl.push_back(mk(0, 1, 8,  32'h88,       0, 0,  8,  3,  1, 32'h88,       1, 32'h33,       1, 1, 1));
        tbl.push_back(mk(0, 0, 0,  32'h0,        0, 0,  8,  8,  1, 32'h88,       1, 32'h88,       1, 0, 0));
        tbl.push_back(mk(0, 1, 4,  32'h7,        1, 4,  4,  4,  1, 32'h7,        1, 32'h7,        1, 0, 0));
        tbl.push_back(mk(0, 0, 0,  32'h0,        0, 0,  4,  4,  1, 32'h7,        0, 32'h7,        0, 1, 1));
        tbl.push_back(mk(0, 0, 0,  32'h0,        1, 9,  9,  4,  1, 32'h0,        1, 32'h7,        0, 1, 1));
        tbl.push_back(mk(0, 0, 0,  32'h0,        0, 0,  9,  4,  1, 32'h0,        0, 32'h7,        0, 1, 2));
        tbl.push_back(mk(0, 1, 9,  32'h99,       1, 6,  6,  9,  1, 32'h0,        1, 32'h99,       1, 1, 2));
        tbl.push_back(mk(0, 0, 0,  32'h0,        0, 0,  6,  9,  1, 32'h0,        0, 32'h99,       1, 1, 2));
        tbl.push_back(mk(0, 0, 0,  32'h0,        1, 4,  4,  6,  1, 32'h7,        0, 32'h0,        0, 1, 2));
        tbl.push_back(mk(0, 1, 10, 32'hA,        0, 0,  4,  10, 1, 32'h7,        0, 32'hA,        1, 1, 2));
        tbl.push_back(mk(0, 0, 0,  32'h0,        1, 11, 10, 11, 1, 32'hA,        1, 32'h0,        1, 1, 2));
        tbl.push_back(mk(1, 1, 2,  32'h22,       0, 0,  11, 4,  1, 32'h0,        0, 32'h7,        0, 1, 3));
        tbl.push_back(mk(0, 0, 0,  32'h0,        0, 0,  2,  4,  1, 32'h0,        1, 32'h0,        1, 0, 0));
        tbl.push_back(mk(0, 0, 0,  32'h0,        0, 0,  29, 11, 1, 32'h50,       1, 32'h0,        1, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i], i);
        end

        // Fill the scoreboard completely, register 0 included (must be ignored)
        for (int i = 0; i < 32; i++) begin
            step(mk(0, 0, 0, 32'h0, 1, 5'(i), 0, 0, 1, 32'h0, 1, 32'h0, 1,
                    (i > 1), 6'((i > 1) ? i - 1 : 0)), 100 + i);
        end
        step(mk(0, 0, 0, 32'h0, 1, 5, 0, 0, 1, 32'h0, 1, 32'h0, 1, 1, 6'd31), 140);
        step(mk(0, 0, 0, 32'h0, 0, 0, 0, 0, 1, 32'h0, 1, 32'h0, 1, 1, 6'd31), 141);

        // Drain it again with writes; each write is bypassed to both ports
        for (int i = 1; i < 32; i++) begin
            step(mk(0, 1, 5'(i), 32'(i), 0, 0, 5'(i), 5'(i), 1, 32'(i), 1, 32'(i), 1,
                    1'b1, 6'(32 - i)), 200 + i);
        end
        step(mk(0, 0, 0, 32'h0, 0, 0, 29, 17, 1, 32'd29, 1, 32'd17, 1, 0, 6'd0), 240);

        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard: got %0d leftover entries expected 0", sb_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
